// File: rtl/rvfi_pkg.sv
// Shared RVFI trace types: the per-instruction slot record carried down the shadow pipeline
// and the widths used by the tracker, the psp top and the bench.
package rvfi_pkg;

    localparam int RVFI_XLEN    = 32;
    localparam int RVFI_ORDER_W = 64;
    localparam int RVFI_MASK_W  = 4;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            insn;
        logic [RVFI_XLEN-1:0]   pc_rdata;
        logic [RVFI_XLEN-1:0]   pc_wdata;
        logic [4:0]             rs1_addr;
        logic [4:0]             rs2_addr;
        logic [RVFI_XLEN-1:0]   rs1_rdata;
        logic [RVFI_XLEN-1:0]   rs2_rdata;
        logic [4:0]             rd_addr;
        logic [RVFI_XLEN-1:0]   rd_wdata;
        logic [RVFI_XLEN-1:0]   mem_addr;
        logic [RVFI_MASK_W-1:0] mem_rmask;
        logic [RVFI_MASK_W-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]   mem_rdata;
        logic [RVFI_XLEN-1:0]   mem_wdata;
    } rvfi_slot_t;

    // Data lanes carry nothing meaningful when the matching byte mask is empty.
    function automatic logic [RVFI_XLEN-1:0] mask_data(input logic [RVFI_MASK_W-1:0] mask,
                                                       input logic [RVFI_XLEN-1:0]   data);
        return (mask != '0) ? data : '0;
    endfunction

endpackage

// File: rtl/rvfi_if.sv
// RVFI retirement bundle: the tracker drives it (master), psp_rvfimon consumes it (slave).
interface rvfi_if #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
);

    logic                               rvfi_valid;
    logic [ORDER_W-1:0]                 rvfi_order;
    logic [31:0]                        rvfi_insn;
    logic [XLEN-1:0]                    rvfi_pc_rdata;
    logic [XLEN-1:0]                    rvfi_pc_wdata;
    logic [4:0]                         rvfi_rs1_addr;
    logic [4:0]                         rvfi_rs2_addr;
    logic [XLEN-1:0]                    rvfi_rs1_rdata;
    logic [XLEN-1:0]                    rvfi_rs2_rdata;
    logic [4:0]                         rvfi_rd_addr;
    logic [XLEN-1:0]                    rvfi_rd_wdata;
    logic [XLEN-1:0]                    rvfi_mem_addr;
    logic [rvfi_pkg::RVFI_MASK_W-1:0]   rvfi_mem_rmask;
    logic [rvfi_pkg::RVFI_MASK_W-1:0]   rvfi_mem_wmask;
    logic [XLEN-1:0]                    rvfi_mem_rdata;
    logic [XLEN-1:0]                    rvfi_mem_wdata;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );

endinterface

// File: rtl/rvfi_stage_reg.sv
// One shadow-pipeline slot: holds an rvfi_slot_t, cleared synchronously, loaded when the pipe moves.
module rvfi_stage_reg
    import rvfi_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  rvfi_slot_t d,
    output rvfi_slot_t q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rvfi_tracker.sv
// Shadows the psp ID->EX->MEM->WB pipeline and emits one registered RVFI packet per retired
// instruction, together with the retirement order counter.
module rvfi_tracker
    import rvfi_pkg::*;
#(
    parameter int XLEN    = RVFI_XLEN,
    parameter int ORDER_W = RVFI_ORDER_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pipe_stall,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [31:0]            id_insn,
    input  logic [31:0]            id_pc,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic [XLEN-1:0]        ex_rs1_data,
    input  logic [XLEN-1:0]        ex_rs2_data,
    input  logic [XLEN-1:0]        ex_pc_next,
    input  logic [XLEN-1:0]        mem_addr,
    input  logic [RVFI_MASK_W-1:0] mem_rmask,
    input  logic [RVFI_MASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]        mem_rdata,
    input  logic [XLEN-1:0]        mem_wdata,
    input  logic [4:0]             wb_rd_addr,
    input  logic [XLEN-1:0]        wb_rd_wdata,
    rvfi_if.master                 rvfi
);

    rvfi_slot_t         ex_d, ex_q;
    rvfi_slot_t         mem_d, mem_q;
    rvfi_slot_t         wb_d, wb_q;
    rvfi_slot_t         pkt_d, pkt_q;
    logic [ORDER_W-1:0] order_cnt;
    logic [ORDER_W-1:0] order_q;
    logic               advance;
    logic               retire;

    assign advance = ~pipe_stall;
    assign retire  = advance & wb_q.valid;

    // Each slot's next value is the slot it leaves plus whatever that stage exposes this cycle.
    always_comb begin
        ex_d          = '0;
        ex_d.valid    = id_valid & ~flush;
        ex_d.insn     = id_insn;
        ex_d.pc_rdata = id_pc;
        ex_d.rs1_addr = id_rs1_addr;
        ex_d.rs2_addr = id_rs2_addr;

        mem_d           = ex_q;
        mem_d.rs1_rdata = ex_rs1_data;
        mem_d.rs2_rdata = ex_rs2_data;
        mem_d.pc_wdata  = ex_pc_next;

        wb_d           = mem_q;
        wb_d.mem_addr  = mem_addr;
        wb_d.mem_rmask = mem_rmask;
        wb_d.mem_wmask = mem_wmask;
        wb_d.mem_rdata = mask_data(mem_rmask, mem_rdata);
        wb_d.mem_wdata = mask_data(mem_wmask, mem_wdata);

        pkt_d          = wb_q;
        pkt_d.rd_addr  = wb_rd_addr;
        pkt_d.rd_wdata = (wb_rd_addr == 5'd0) ? '0 : wb_rd_wdata;
    end

    rvfi_stage_reg u_ex (
        .clk   (clk),
        .clear (reset),
        .load  (advance),
        .d     (ex_d),
        .q     (ex_q)
    );

    rvfi_stage_reg u_mem (
        .clk   (clk),
        .clear (reset),
        .load  (advance),
        .d     (mem_d),
        .q     (mem_q)
    );

    rvfi_stage_reg u_wb (
        .clk   (clk),
        .clear (reset),
        .load  (advance),
        .d     (wb_d),
        .q     (wb_q)
    );

    // Only the valid bit drops between retirements; the packet fields keep showing the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q     <= '0;
            order_q   <= '0;
            order_cnt <= '0;
        end else if (retire) begin
            pkt_q     <= pkt_d;
            order_q   <= order_cnt;
            order_cnt <= order_cnt + ORDER_W'(1);
        end else begin
            pkt_q.valid <= 1'b0;
        end
    end

    assign rvfi.rvfi_valid     = pkt_q.valid;
    assign rvfi.rvfi_order     = order_q;
    assign rvfi.rvfi_insn      = pkt_q.insn;
    assign rvfi.rvfi_pc_rdata  = pkt_q.pc_rdata;
    assign rvfi.rvfi_pc_wdata  = pkt_q.pc_wdata;
    assign rvfi.rvfi_rs1_addr  = pkt_q.rs1_addr;
    assign rvfi.rvfi_rs2_addr  = pkt_q.rs2_addr;
    assign rvfi.rvfi_rs1_rdata = pkt_q.rs1_rdata;
    assign rvfi.rvfi_rs2_rdata = pkt_q.rs2_rdata;
    assign rvfi.rvfi_rd_addr   = pkt_q.rd_addr;
    assign rvfi.rvfi_rd_wdata  = pkt_q.rd_wdata;
    assign rvfi.rvfi_mem_addr  = pkt_q.mem_addr;
    assign rvfi.rvfi_mem_rmask = pkt_q.mem_rmask;
    assign rvfi.rvfi_mem_wmask = pkt_q.mem_wmask;
    assign rvfi.rvfi_mem_rdata = pkt_q.mem_rdata;
    assign rvfi.rvfi_mem_wdata = pkt_q.mem_wdata;

endmodule
